// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Segment patterns are active-low, ordered g,f,e,d,c,b,a.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DEC_DIGITS = 6;
  localparam int HEX_DIGITS = 5;
  localparam int BIN_WIDTH  = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  // Entry [n] is the pattern for hex digit n (listed F down to 0).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_display_driver_bin2bcd17.sv
// Sequential double-dabble: converts a 17-bit binary word to 6 BCD digits,
// one iteration per clock, BIN_WIDTH iterations after a start pulse.
module bin2bcd17
  import seg7_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin,
  output logic                 busy,
  output logic                 done,
  output logic [23:0]          bcd
);

  logic [BIN_WIDTH-1:0] r_bin;
  logic [23:0]          r_bcd;
  logic [4:0]           r_cnt;
  logic                 r_busy;
  logic [23:0]          w_adj;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5) ? r_bcd[4*gi +: 4] + 4'd3
                                                         : r_bcd[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_bin  <= bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bcd <= {w_adj[22:0], r_bin[BIN_WIDTH-1]};
      r_bin <= {r_bin[BIN_WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'(BIN_WIDTH - 1)) r_busy <= 1'b0;
    end
  end

  // High during the final iteration, so the result is valid the next cycle.
  assign done = r_busy && (r_cnt == 5'(BIN_WIDTH - 1));
  assign busy = r_busy;
  assign bcd  = r_bcd;

endmodule

// File: rtl/seg7_display_driver.sv
// 8-digit multiplexed seven-segment driver showing a 17-bit value in decimal
// or hex, with leading-zero blanking and a glitch-free display buffer.
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIN_WIDTH-1:0] value,
  input  logic                 dec_mode,
  output logic [7:0]           an,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic                 busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  conv_state_t          r_state, w_state_next;
  logic [BIN_WIDTH-1:0] r_last_value, r_cap_value;
  logic                 r_last_mode, r_cap_mode;
  logic [23:0]          r_buf_digits;
  logic                 r_buf_mode;
  logic [CNT_W-1:0]     r_refresh_cnt;
  logic [2:0]           r_scan_idx;
  logic [7:0]           r_an;
  logic [6:0]           r_seg;

  logic                 w_changed, w_start;
  logic                 w_conv_busy, w_conv_done;
  logic [23:0]          w_conv_bcd;
  logic [DEC_DIGITS-1:0] w_nz;
  logic [NUM_DIGITS-1:0] w_lit;
  logic [31:0]          w_digits_ext;
  logic [3:0]           w_nibble;

  assign w_changed = {value, dec_mode} != {r_last_value, r_last_mode};
  assign w_start   = (r_state == ST_IDLE) && w_changed && dec_mode;

  bin2bcd17 u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .bin   (value),
    .busy  (w_conv_busy),
    .done  (w_conv_done),
    .bcd   (w_conv_bcd)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_changed) w_state_next = dec_mode ? ST_SHIFT : ST_DONE;
      // The converter going idle on its own also ends SHIFT, so it can never hang.
      ST_SHIFT: if (w_conv_done || !w_conv_busy) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_value <= '0;
      r_last_mode  <= 1'b1;
      r_cap_value  <= '0;
      r_cap_mode   <= 1'b1;
      r_buf_digits <= '0;
      r_buf_mode   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && w_changed) begin
        r_cap_value  <= value;
        r_cap_mode   <= dec_mode;
        r_last_value <= value;
        r_last_mode  <= dec_mode;
      end
      if (r_state == ST_DONE) begin
        r_buf_digits <= r_cap_mode ? w_conv_bcd : {7'b0, r_cap_value};
        r_buf_mode   <= r_cap_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= '0;
    end else if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= r_scan_idx + 3'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEC_DIGITS; gi++) begin : g_nz
      assign w_nz[gi] = |r_buf_digits[4*gi +: 4];
    end
    // A digit lights only if something nonzero sits at or above it.
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lit
      if (gi == 0) begin : g_first
        assign w_lit[gi] = 1'b1;
      end else if (gi < DEC_DIGITS) begin : g_mid
        assign w_lit[gi] = (r_buf_mode || (gi < HEX_DIGITS)) && (|w_nz[DEC_DIGITS-1:gi]);
      end else begin : g_off
        assign w_lit[gi] = 1'b0;
      end
    end
  endgenerate

  assign w_digits_ext = {8'h00, r_buf_digits};
  assign w_nibble     = w_digits_ext[{r_scan_idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
    end else if (w_lit[r_scan_idx]) begin
      r_an  <= ~(8'd1 << r_scan_idx);
      r_seg <= SEG_TABLE[w_nibble];
    end else begin
      r_an  <= 8'hFF;
      r_seg <= 7'h7F;
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;
  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_seg7_display_driver.sv
// Self-checking bench for seg7_display_driver: table-driven vectors with a
// scoreboard queue, plus hand-written reset and mid-conversion sequences.
module tb_seg7_display_driver;

  logic        clk;
  logic        reset;
  logic [16:0] value;
  logic        dec_mode;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [16:0]      value;
    logic             mode;
    int               busy_len;
    logic [7:0][6:0]  segs;
  } vec_t;

  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  vec_t vecs [14];
  vec_t sb_q [$];
  logic [6:0] obs_seg [8];
  bit         obs_bad_an;
  bit         obs_busy;

  seg7_display_driver #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .dec_mode (dec_mode),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t make_vec(input logic [16:0] v, input logic m);
    vec_t r;
    int dig [8];
    int nd, msd, x;
    r.value    = v;
    r.mode     = m;
    r.busy_len = m ? 18 : 1;
    nd  = m ? 6 : 5;
    x   = int'(v);
    msd = 0;
    for (int i = 0; i < 8; i++) dig[i] = 0;
    for (int i = 0; i < nd; i++) begin
      if (m) begin
        dig[i] = x % 10;
        x = x / 10;
      end else begin
        dig[i] = (x >> (4 * i)) & 15;
      end
      if (dig[i] != 0) msd = i;
    end
    for (int i = 0; i < 8; i++)
      r.segs[i] = (i <= msd && i < nd) ? PAT[dig[i]] : 7'h7F;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endtask

  // Observe more than one full scan frame; record the pattern seen per digit.
  task automatic collect_frame();
    for (int i = 0; i < 8; i++) obs_seg[i] = 7'h7F;
    obs_bad_an = 1'b0;
    obs_busy   = 1'b0;
    repeat (36) begin
      @(negedge clk);
      if (busy) obs_busy = 1'b1;
      if (an != 8'hFF) begin
        if ($countones(~an) != 1) obs_bad_an = 1'b1;
        else for (int k = 0; k < 8; k++) if (!an[k]) obs_seg[k] = seg;
      end
    end
  endtask

  task automatic check_frame(input string tag, input vec_t e);
    collect_frame();
    check({tag, " an one-hot"}, 32'(obs_bad_an), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s digit%0d seg", tag, i), 32'(obs_seg[i]), 32'(e.segs[i]));
  endtask

  // Called at a negedge right after driving; returns the busy run length.
  task automatic measure_busy(output int len);
    int waited = 0;
    len = 0;
    while (!busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    while (busy && len < 60) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t e, e100, e200;
    int   len, len1, len2, gap, waited;
    logic [16:0] rv;
    logic        rm, pm;
    logic [16:0] pv;

    reset    = 1'b1;
    value    = 17'd0;
    dec_mode = 1'b1;
    repeat (3) @(negedge clk);
    check("reset an",   32'(an),   32'hFF);
    check("reset seg",  32'(seg),  32'h7F);
    check("reset busy", 32'(busy), 32'd0);
    check("reset dp",   32'(dp),   32'd1);
    reset = 1'b0;
    @(negedge clk);
    e = make_vec(17'd0, 1'b1);
    collect_frame();
    check("post-reset no conversion", 32'(obs_busy), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("post-reset digit%0d seg", i), 32'(obs_seg[i]), 32'(e.segs[i]));

    vecs[0] = make_vec(17'd12345,  1'b1);
    vecs[1] = make_vec(17'd131071, 1'b1);
    vecs[2] = make_vec(17'h1ABCD,  1'b0);
    vecs[3] = make_vec(17'h00000,  1'b0);
    vecs[4] = make_vec(17'h00F00,  1'b0);
    vecs[5] = make_vec(17'd255,    1'b1);
    vecs[6] = make_vec(17'd100000, 1'b1);
    vecs[7] = make_vec(17'h10000,  1'b0);
    pv = 17'h10000;
    pm = 1'b0;
    for (int i = 8; i < 14; i++) begin
      rv = 17'($urandom_range(0, 131071));
      rm = 1'($urandom_range(0, 1));
      if (rv == pv && rm == pm) rv = rv ^ 17'd1;
      if (rv == 17'd100) rv = 17'd101;
      vecs[i] = make_vec(rv, rm);
      pv = rv;
      pm = rm;
    end

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      sb_q.push_back(vecs[i]);
      value    = vecs[i].value;
      dec_mode = vecs[i].mode;
      measure_busy(len);
      e = sb_q.pop_front();
      check($sformatf("v%0d %0s %0d busy cycles", i, e.mode ? "dec" : "hex", e.value),
            32'(len), 32'(e.busy_len));
      @(negedge clk);
      check_frame($sformatf("v%0d", i), e);
    end

    // Input change three cycles into a conversion is deferred, not merged.
    e100 = make_vec(17'd100, 1'b1);
    e200 = make_vec(17'd200, 1'b1);
    @(negedge clk);
    value = 17'd100;
    dec_mode = 1'b1;
    waited = 0;
    while (!busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    len1 = 0;
    while (busy && len1 < 60) begin
      len1++;
      if (len1 == 3) value = 17'd200;
      @(negedge clk);
    end
    check("chg first busy run", 32'(len1), 32'd18);
    gap = 0;
    while (!busy && gap < 40) begin
      gap++;
      @(negedge clk);
    end
    check("chg idle gap", 32'(gap), 32'd1);
    len2 = 0;
    while (busy && len2 < 60) begin
      len2++;
      if (an != 8'hFF)
        for (int k = 0; k < 8; k++)
          if (!an[k]) check($sformatf("chg shows 100 digit%0d", k), 32'(seg), 32'(e100.segs[k]));
      @(negedge clk);
    end
    check("chg second busy run", 32'(len2), 32'd18);
    @(negedge clk);
    check_frame("chg 200", e200);

    // Reset ten cycles into a conversion of 999 aborts it.
    @(negedge clk);
    value = 17'd999;
    waited = 0;
    while (!busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    len = 0;
    while (busy && len < 10) begin
      len++;
      if (len < 10) @(negedge clk);
    end
    check("abort reached cycle 10", 32'(len), 32'd10);
    reset = 1'b1;
    value = 17'd0;
    @(negedge clk);
    check("abort busy after reset", 32'(busy), 32'd0);
    check("abort an after reset",   32'(an),   32'hFF);
    check("abort seg after reset",  32'(seg),  32'h7F);
    reset = 1'b0;
    e = make_vec(17'd0, 1'b1);
    collect_frame();
    check("abort no restart", 32'(obs_busy), 32'd0);
    for (int i = 0; i < 8; i++)
      check($sformatf("abort digit%0d seg", i), 32'(obs_seg[i]), 32'(e.segs[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_display_driver.md
SEG7_DISPLAY_DRIVER -- requirements
Module: seg7_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (100 MHz -> 1 kHz per digit).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high.
REQ-004 SHALL have port value  input  17  unsigned number to display (calculator display word).
REQ-005 SHALL have port dec_mode  input  1  1 = decimal, 0 = hexadecimal.
REQ-006 SHALL have port an  output  8  digit anodes, active-low, an[0] = rightmost digit.
REQ-007 SHALL have port seg  output  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a.
REQ-008 SHALL have port dp  output  1  decimal point, active-low, always 1 (off).
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-010 SHALL register last_value and last_mode, holding the (value, dec_mode) pair last accepted.
REQ-011 SHALL run converter FSM states IDLE, SHIFT, DONE.
REQ-012 In IDLE, if {value,dec_mode} != {last_value,last_mode}, SHALL capture both at that edge and update last_*. It SHALL go to SHIFT if dec_mode=1, else to DONE.
REQ-013 SHIFT SHALL perform one double-dabble iteration per cycle (add 3 to each BCD nibble >=5, then shift left one bit) for exactly 17 cycles, producing 6 BCD digits, then go to DONE.
REQ-014 DONE SHALL write the result into the display buffer in one cycle and return to IDLE.
   - Decimal: 6 BCD digits.
   - Hex: the 5 nibbles of the captured value; the top nibble is 0 or 1.
REQ-015 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
   - Decimal: busy high for 18 consecutive cycles.
   - Hex: busy high for 1 cycle.
REQ-016 Changes to value or dec_mode while busy=1 SHALL NOT affect the running conversion. They SHALL be detected in IDLE afterwards by the REQ-012 compare.
REQ-017 The display buffer SHALL change only in DONE; the display never shows a partial result.
REQ-018 A free-running refresh counter SHALL count 0..REFRESH_DIV-1 and wrap. At each wrap the scan index (0..7) SHALL advance, wrapping 7->0.
REQ-019 an and seg SHALL be registered, and SHALL update on the cycle after each scan-index change.
   - an = one-hot-low at the scan index when that digit is lit, else 8'hFF.
REQ-020 Lit-digit rules:
   - Digit 0 is always lit.
   - Digit i>0 is lit only if i < 6 (decimal) or i < 5 (hex), and the buffer has a nonzero digit at some position >= i (leading-zero blanking).
   - Digits 6 and 7 are never lit.
REQ-021 seg SHALL use standard hex patterns for 0-F, e.g. 0=1000000, 1=1111001, 7=1111000, A=0001000, D=0100001.
REQ-022 Digit blanking SHALL use the buffer's mode bit, written in DONE together with the digits, not the live dec_mode.

Reset
REQ-023 On reset the following SHALL take these values:
   - FSM = IDLE, busy = 0.
   - Display buffer = all zero, mode bit = 1.
   - last_value = 0, last_mode = 1.
   - Refresh counter = 0, scan index = 0.
   - an = 8'hFF, seg = 7'h7F, dp = 1.
REQ-024 Reset asserted mid-conversion SHALL abort it with no buffer write; busy SHALL be 0 on the cycle after reset is sampled.

Structure
REQ-025 A shared package seg7_pkg SHALL hold:
   - the FSM state enum;
   - the 16-entry segment pattern table;
   - constants NUM_DIGITS=8, DEC_DIGITS=6, HEX_DIGITS=5, BIN_WIDTH=17.
REQ-026 The sequential double-dabble SHALL be one sub-module, bin2bcd17, with start/busy/done and a 24-bit BCD output. Scan, blanking and decode SHALL stay in the top module.

Verification (REFRESH_DIV=4)
REQ-027 Reset with value=0 and dec_mode=1 -> an=FF, seg=7F, busy=0 during reset. Afterwards only digit 0 lights, seg=1000000.
REQ-028 value=12345, dec_mode=1 -> busy high 18 cycles. Buffer = 0,1,2,3,4,5 (msd..lsd); digit 4 shows 1111001, digit 5 dark.
REQ-029 value=131071, dec_mode=1 -> digits 1,3,1,0,7,1 all lit, including the internal zero (seg=1000000 at digit 2).
REQ-030 value=17'h1ABCD, dec_mode=0 -> busy high 1 cycle. Digits 4..0 = 1,A,B,C,D; digits 5-7 dark.
REQ-031 value=100, then value=200 three cycles into the conversion -> 100 is displayed first, then a second 18-cycle conversion runs and 200 is displayed.
REQ-032 Reset pulse at cycle 10 of a conversion of 999 -> busy=0 the next cycle and the display shows a single 0.
